// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word transmitter and its SCK divider.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD
    } spi_ctrl_state_t;

    localparam int SPI_WORD_BITS = 32;
    localparam int SPI_BYTE_BITS = 8;
    localparam int SPI_CNT_W     = 6;

    // A divide-by-one counter still needs one bit to hold its (constant zero) value.
    function automatic int div_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// Loadable down-counter producing a one-cycle tick every CLK_DIV cycles while enabled.
module spi_sck_divider
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam int            CW     = div_cnt_width(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = en && (cnt_q == '0);
        if (load) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = tick ? RELOAD : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_word_transmitter.sv
// Mode-0 SPI initiator: one 32-bit word per frame as four MSB-first bytes,
// capturing the 32 concurrent MISO bits into dout at frame end.
module spi_word_transmitter
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic        byte_done,
    output logic [31:0] dout,
    output logic        ss,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);

    spi_ctrl_state_t          state_q, state_d;
    logic [SPI_WORD_BITS-1:0] tx_q, tx_d;
    logic [SPI_WORD_BITS-1:0] rx_q, rx_d;
    logic [SPI_WORD_BITS-1:0] dout_q, dout_d;
    logic [SPI_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SPI_CNT_W-1:0]     bit_cnt_inc;
    logic                     sck_q, sck_d;
    logic                     ss_q, ss_d;
    logic                     mosi_q, mosi_d;
    logic                     done_q, done_d;
    logic                     byte_done_q, byte_done_d;

    logic div_en;
    logic div_load;
    logic tick;

    assign div_en   = (state_q != IDLE);
    assign div_load = (state_q == IDLE) && start;

    spi_sck_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .load (div_load),
        .tick (tick)
    );

    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        dout_d      = dout_q;
        bit_cnt_d   = bit_cnt_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        done_d      = 1'b0;
        byte_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d      = din;
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    sck_d     = 1'b0;
                    ss_d      = 1'b0;
                    mosi_d    = din[SPI_WORD_BITS-1];
                    state_d   = SETUP;
                end
            end

            // The first rising edge ends the setup window and samples the first MISO bit.
            SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[SPI_WORD_BITS-2:0], miso};
                    state_d = TRANSFER;
                end
            end

            TRANSFER: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[SPI_WORD_BITS-2:0], miso};
                    end else begin
                        sck_d       = 1'b0;
                        bit_cnt_d   = bit_cnt_inc;
                        byte_done_d = (bit_cnt_inc[2:0] == 3'd0);
                        if (bit_cnt_inc == SPI_CNT_W'(SPI_WORD_BITS)) begin
                            state_d = HOLD;
                        end else begin
                            tx_d   = {tx_q[SPI_WORD_BITS-2:0], 1'b0};
                            mosi_d = tx_q[SPI_WORD_BITS-2];
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            dout_q      <= '0;
            bit_cnt_q   <= '0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            dout_q      <= dout_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign byte_done = byte_done_q;
    assign dout      = dout_q;
    assign ss        = ss_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;

endmodule

// File: doc/spi_word_transmitter.md
# spi_word_transmitter

SPI controller (initiator) that sends one 32-bit word as four MSB-first bytes in a single slave-select frame, SPI mode 0, while capturing the concurrent 32 MISO bits. It is the driving end for the team's SPI peripheral and four-byte word assembly path: a host-side block loads a word, pulses `start`, and the peripheral side sees four consecutive byte completions whose first byte is `din[31:24]`.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles (H below); legal range 1..255.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a transfer; accepted only when `busy`=0.
- `din`  input  32  word to send; latched on the accepting edge.
- `busy`  output  1  high from the cycle after acceptance until the frame ends.
- `done`  output  1  one-cycle pulse at frame end.
- `byte_done`  output  1  one-cycle pulse after each 8th SCK falling edge (4 per frame).
- `dout`  output  32  word received on `miso`; updated only at `done`.
- `ss`  output  1  slave select, active low.
- `sck`  output  1  serial clock, idles low.
- `mosi`  output  1  serial data out.
- `miso`  input  1  serial data in.

## Operation
- Reset values: `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `byte_done`=0, `dout`=0.
- FSM states:
  - IDLE: `start`=1 latches `din` into the TX shift register, clears the RX shift register and the bit counter, then moves to SETUP.
  - SETUP: `ss`=0, `mosi`=`din[31]`. After H cycles, go to TRANSFER.
  - TRANSFER: `sck` toggles every H cycles.
    - Rising edge: shift `miso` into RX LSB.
    - Falling edge: bit counter +1. If bits remain, shift TX left and drive the next bit on `mosi`. `byte_done` pulses when the count is a multiple of 8.
    - After the 32nd falling edge, go to HOLD.
  - HOLD: `sck`=0, `ss` stays 0 for H cycles, then return to IDLE. On that return: `ss`=1, `mosi`=0, `done`=1, `dout`=RX word.
- Bit order: `din[31]` is sent first, `din[0]` last. The first MISO bit lands in `dout[31]`.
- `start` while `busy`=1 is ignored: no queueing, and `din` changes are not observed.
- Counters: 6-bit bit counter (0..32); divider counter sized by `$clog2(CLK_DIV)`, minimum 1 bit. Saturation or wrap is never reached in legal operation.
- Reset mid-frame: at the next edge all outputs return to reset values. No `done`, no `byte_done`. `dout` is cleared.

## Timing
- E0 is the edge that samples `start`=1 in IDLE.
- `ss` falls after E0, and `busy`=1 from the same point.
- SCK edges, for k=0..31:
  - Rising at E0+H+2kH.
  - Falling at E0+2H+2kH.
- Last falling edge: E0+64H.
- At E0+65H: `ss`=1, `done`=1, `busy`=0.
- Frame length: 65H cycles; H=4 gives 260 cycles.
- `mosi` changes only on SCK falling edges or at SETUP entry. This guarantees at least H cycles of setup and hold around each rising edge.
- `byte_done` pulses coincide with the falling edges at E0+16H, 32H, 48H, 64H.
- Back-to-back operation: `start` held high during the `done` cycle is accepted on the next edge. Minimum `ss`-high gap is 1 cycle.
- `done` and `byte_done` are registered and never high for two consecutive cycles.

## Structure
- Package `spi_pkg`:
  - State enum `spi_ctrl_state_t` {IDLE, SETUP, TRANSFER, HOLD}.
  - Constants `SPI_WORD_BITS`=32 and `SPI_BYTE_BITS`=8.
- Sub-module `spi_sck_divider`: loadable down-counter that emits a one-cycle `tick` every `CLK_DIV` cycles while enabled. The FSM toggles `sck` on `tick`.
- TX and RX shift registers, the bit counter and the FSM live in the top module.

## Test plan
- Reset, then idle 20 cycles -> `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `dout`=0; no pulses.
- `din`=0xA5C3_0F81, CLK_DIV=4, `miso` tied to `mosi` -> MOSI bits sampled on rising edges read 0xA5C30F81 MSB-first; `done` at E0+260; `dout`=0xA5C30F81; `byte_done` exactly at E0+64, 128, 192, 256.
- `miso` driven with 0x1234_5678 MSB-first on falling edges, `din`=0 -> `dout`=0x12345678 at `done`; `mosi` stays 0.
- `start` re-pulsed with `din`=0xFFFF_FFFF mid-frame of 0x0000_0001 -> the 0xFFFFFFFF request is ignored; exactly one frame is sent, with value 0x00000001.
- `rst` asserted at E0+100 (CLK_DIV=2) -> next cycle all outputs are at reset values, and no `done` follows. A new `start` then completes normally in 130 cycles.
- CLK_DIV=1, `start` held high continuously -> frames of 65 cycles separated by exactly one `ss`-high cycle; each `done` is followed by a new frame.
